unique_selector: RTL and testbench

- Responder end of the "us" request/done interface driven by the game FSM.
- On each request it returns a pseudo-random gopher index in 0..NUM_SLOTS-1 that has not yet been issued this round.
- It raises us_all_selected once every index has been issued, and keeps a used-mask until the round is cleared.
- Sits beside the game FSM in the top module and is fed by a free-running LFSR.

---
 rtl/unique_selector_if.sv | 22 ++
 rtl/unique_selector.sv | 167 ++++++++++++++++
 tb/tb_unique_selector.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/unique_selector_if.sv
// Request/done handshake between the game FSM (master) and the
// unique index selector (slave).
interface unique_selector_if;
  logic       us_req;
  logic [3:0] us_selected_number;
  logic       us_done;
  logic       us_all_selected;

  modport master (
    output us_req,
    input  us_selected_number,
    input  us_done,
    input  us_all_selected
  );

  modport slave (
    input  us_req,
    output us_selected_number,
    output us_done,
    output us_all_selected
  );
endinterface

// File: rtl/unique_selector.sv
// Unique pseudo-random index selector.
// Each request returns an index in 0..NUM_SLOTS-1 not yet issued this
// round. The starting point comes from a free-running 16-bit Galois LFSR,
// then a linear probe walks forward one slot per cycle until it finds a
// free index. A used-mask and issue count persist until round_clear.
module unique_selector #(
  parameter int          NUM_SLOTS  = 16,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter bit          AUTO_CLEAR = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  unique_selector_if.slave us,
  input  logic             round_clear,
  input  logic             seed_load,
  input  logic [15:0]      seed_in,
  output logic [4:0]       sel_count
);

  localparam logic [4:0]  SLOTS = 5'(NUM_SLOTS);
  localparam logic [15:0] POLY  = 16'hB400;

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    DONE,
    WAIT_REL
  } state_t;

  state_t               state_q, state_d;
  logic [15:0]          lfsr_q, lfsr_d;
  logic [3:0]           ptr_q, ptr_d;
  logic [NUM_SLOTS-1:0] mask_q, mask_d;
  logic [4:0]           count_q, count_d;
  logic [3:0]           num_q, num_d;
  logic                 done_q, done_d;
  logic                 all_q, all_d;

  logic [15:0]          mask_wide;
  logic [15:0]          ptr_onehot;
  logic                 hit;
  logic                 exhausted;

  // Widen the mask to 16 bits so any 4-bit probe pointer indexes it safely.
  always_comb begin
    mask_wide                = '0;
    mask_wide[NUM_SLOTS-1:0] = mask_q;
  end

  // Pointers at or beyond NUM_SLOTS can never hit.
  assign hit        = ({1'b0, ptr_q} < SLOTS) && !mask_wide[ptr_q];
  assign exhausted  = (count_q == SLOTS);
  assign ptr_onehot = 16'd1 << ptr_q;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values and process order cannot create races.
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: one issue per request assertion.
  always_comb begin
    // NOTE: a default at the top of every combinational block guarantees
    // each path assigns the output, so no latch is inferred.
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (us.us_req && (!exhausted || AUTO_CLEAR)) begin
          state_d = SEARCH;
        end
      end
      SEARCH: begin
        if (hit) begin
          state_d = DONE;
        end
      end
      DONE:     state_d = WAIT_REL;
      WAIT_REL: begin
        if (!us.us_req) begin
          state_d = IDLE;
        end
      end
      default:  state_d = IDLE;
    endcase
  end

  // Datapath next values: LFSR, probe pointer, mask, count and outputs.
  always_comb begin
    lfsr_d  = lfsr_q[0] ? ((lfsr_q >> 1) ^ POLY) : (lfsr_q >> 1);
    ptr_d   = ptr_q;
    mask_d  = mask_q;
    count_d = count_q;
    num_d   = num_q;
    done_d  = 1'b0;

    if (seed_load) begin
      lfsr_d = (seed_in == 16'd0) ? LFSR_SEED : seed_in;
    end

    case (state_q)
      IDLE: begin
        if (us.us_req) begin
          if (!exhausted) begin
            ptr_d = lfsr_q[3:0];
          end else if (AUTO_CLEAR) begin
            mask_d  = '0;
            count_d = '0;
            ptr_d   = lfsr_q[3:0];
          end
        end
      end
      SEARCH: begin
        if (hit) begin
          num_d   = ptr_q;
          mask_d  = mask_q | ptr_onehot[NUM_SLOTS-1:0];
          count_d = count_q + 5'd1;
          done_d  = 1'b1;
        end else begin
          ptr_d = ptr_q + 4'd1;
        end
      end
      default: ;
    endcase

    // A round clear wins over any mask/count update on the same edge but
    // never disturbs the search or the index being delivered.
    if (round_clear) begin
      mask_d  = '0;
      count_d = '0;
    end

    // Registered from the next count so it rises with the final done.
    all_d = (count_d == SLOTS);
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_q  <= LFSR_SEED;
      ptr_q   <= '0;
      mask_q  <= '0;
      count_q <= '0;
      num_q   <= '0;
      done_q  <= 1'b0;
      all_q   <= 1'b0;
    end else begin
      lfsr_q  <= lfsr_d;
      ptr_q   <= ptr_d;
      mask_q  <= mask_d;
      count_q <= count_d;
      num_q   <= num_d;
      done_q  <= done_d;
      all_q   <= all_d;
    end
  end

  assign us.us_selected_number = num_q;
  assign us.us_done            = done_q;
  assign us.us_all_selected    = all_q;
  assign sel_count             = count_q;

endmodule

// File: tb/tb_unique_selector.sv
// Bench for unique_selector: three instances (16 slots, 9 slots, 4 slots
// with auto-clear) driven from one initial block. A spec-level model tracks
// each LFSR and used-mask to predict the exact issued index and latency;
// expectations are queued at request time and popped at us_done.
module tb_unique_selector;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req;
  logic [2:0]  rclr;
  logic [2:0]  sload;
  logic [15:0] sin [3];
  logic [2:0]  done;
  logic [2:0]  all;
  logic [3:0]  num [3];
  logic [4:0]  cnt [3];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  unique_selector_if bus0 ();
  unique_selector_if bus1 ();
  unique_selector_if bus2 ();

  assign bus0.us_req = req[0];
  assign bus1.us_req = req[1];
  assign bus2.us_req = req[2];
  assign done[0] = bus0.us_done;
  assign done[1] = bus1.us_done;
  assign done[2] = bus2.us_done;
  assign all[0]  = bus0.us_all_selected;
  assign all[1]  = bus1.us_all_selected;
  assign all[2]  = bus2.us_all_selected;
  assign num[0]  = bus0.us_selected_number;
  assign num[1]  = bus1.us_selected_number;
  assign num[2]  = bus2.us_selected_number;

  unique_selector #(.NUM_SLOTS(16), .AUTO_CLEAR(1'b0)) dut0 (
    .clk(clk), .rst(rst), .us(bus0), .round_clear(rclr[0]),
    .seed_load(sload[0]), .seed_in(sin[0]), .sel_count(cnt[0]));
  unique_selector #(.NUM_SLOTS(9), .AUTO_CLEAR(1'b0)) dut1 (
    .clk(clk), .rst(rst), .us(bus1), .round_clear(rclr[1]),
    .seed_load(sload[1]), .seed_in(sin[1]), .sel_count(cnt[1]));
  unique_selector #(.NUM_SLOTS(4), .AUTO_CLEAR(1'b1)) dut2 (
    .clk(clk), .rst(rst), .us(bus2), .round_clear(rclr[2]),
    .seed_load(sload[2]), .seed_in(sin[2]), .sel_count(cnt[2]));

  // ---------------- reference model ----------------
  typedef struct {
    logic [3:0] num;
    logic [4:0] cnt;
    logic       all;
    int         lat;
  } exp_t;

  exp_t        sb [$];
  logic [15:0] m_lfsr [3];
  logic [15:0] m_seen [3];
  int          m_count [3];

  function automatic int slots(input int d);
    case (d)
      0:       return 16;
      1:       return 9;
      default: return 4;
    endcase
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  // Linear probe from the LFSR nibble: returns the index and probe count.
  function automatic void predict(input logic [3:0] ptr0, input logic [15:0] seen,
                                  input int n, output logic [3:0] pick,
                                  output int probes);
    logic [3:0] ptr;
    ptr    = ptr0;
    pick   = '0;
    probes = 17;
    for (int i = 1; i <= 16; i++) begin
      if (int'(ptr) < n && !seen[ptr]) begin
        pick   = ptr;
        probes = i;
        return;
      end
      ptr = ptr + 4'd1;
    end
  endfunction

  always @(posedge clk or negedge rst) begin
    for (int d = 0; d < 3; d++) begin
      if (!rst)          m_lfsr[d] <= 16'hACE1;
      else if (sload[d]) m_lfsr[d] <= (sin[d] == 16'd0) ? 16'hACE1 : sin[d];
      else               m_lfsr[d] <= lfsr_next(m_lfsr[d]);
    end
  end

  // ---------------- tasks ----------------
  // One full handshake on instance d. Optionally fires round_clear on the
  // hit edge, and optionally keeps us_req high for extra cycles after done.
  task automatic do_req(input int d, input bit clr_on_hit, input int hold);
    logic [3:0] pick;
    int         p;
    int         k;
    int         pulses;
    bit         got;
    bit         unstable;
    exp_t       e;
    if (m_count[d] == slots(d)) begin
      m_seen[d]  = '0;
      m_count[d] = 0;
    end
    predict(m_lfsr[d][3:0], m_seen[d], slots(d), pick, p);
    e.num = pick;
    e.cnt = clr_on_hit ? 5'd0 : 5'(m_count[d] + 1);
    e.all = !clr_on_hit && (m_count[d] + 1 == slots(d));
    e.lat = p + 1;
    sb.push_back(e);
    req[d] = 1'b1;
    got    = 1'b0;
    for (k = 1; k <= 40; k++) begin
      @(negedge clk);
      rclr[d] = (clr_on_hit && k == p);
      if (done[d]) begin
        got = 1'b1;
        break;
      end
    end
    rclr[d] = 1'b0;
    e = sb.pop_front();
    n_tests++;
    if (!got) begin
      n_fail++;
      $display("FAIL done_timeout[%0d]: no us_done within 40 cycles, required within %0d", d, e.lat);
    end else begin
      n_tests += 3;
      if (num[d] !== e.num) begin
        n_fail++;
        $display("FAIL number[%0d]: got %0d required %0d", d, num[d], e.num);
      end
      if (cnt[d] !== e.cnt) begin
        n_fail++;
        $display("FAIL sel_count[%0d]: got %0d required %0d", d, cnt[d], e.cnt);
      end
      if (all[d] !== e.all) begin
        n_fail++;
        $display("FAIL all_selected[%0d]: got %0b required %0b", d, all[d], e.all);
      end
      if (k !== e.lat) begin
        n_fail++;
        $display("FAIL latency[%0d]: got %0d required %0d", d, k, e.lat);
      end
    end
    m_seen[d][e.num] = 1'b1;
    m_count[d]++;
    if (clr_on_hit) begin
      m_seen[d]  = '0;
      m_count[d] = 0;
    end
    @(negedge clk);
    n_tests++;
    if (done[d] !== 1'b0) begin
      n_fail++;
      $display("FAIL done_width[%0d]: got %0b required 0", d, done[d]);
    end
    pulses   = 0;
    unstable = 1'b0;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (done[d]) pulses++;
      if (num[d] !== e.num) unstable = 1'b1;
    end
    if (hold > 0) begin
      n_tests += 2;
      if (pulses != 0) begin
        n_fail++;
        $display("FAIL held_req_pulses[%0d]: got %0d extra pulses required 0", d, pulses);
      end
      if (unstable) begin
        n_fail++;
        $display("FAIL number_stable[%0d]: got changing value required %0d", d, e.num);
      end
    end
    req[d] = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_clear(input int d);
    rclr[d] = 1'b1;
    @(negedge clk);
    rclr[d]    = 1'b0;
    m_seen[d]  = '0;
    m_count[d] = 0;
    n_tests += 2;
    if (cnt[d] !== 5'd0) begin
      n_fail++;
      $display("FAIL clear_count[%0d]: got %0d required 0", d, cnt[d]);
    end
    if (all[d] !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_all[%0d]: got %0b required 0", d, all[d]);
    end
  endtask

  task automatic test_reset();
    rst   = 1'b0;
    req   = '0;
    rclr  = '0;
    sload = '0;
    for (int d = 0; d < 3; d++) begin
      sin[d]     = '0;
      m_seen[d]  = '0;
      m_count[d] = 0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      n_tests += 4;
      if (num[d] !== 4'd0)  begin n_fail++; $display("FAIL reset_number[%0d]: got %0d required 0", d, num[d]); end
      if (done[d] !== 1'b0) begin n_fail++; $display("FAIL reset_done[%0d]: got %0b required 0", d, done[d]); end
      if (all[d] !== 1'b0)  begin n_fail++; $display("FAIL reset_all[%0d]: got %0b required 0", d, all[d]); end
      if (cnt[d] !== 5'd0)  begin n_fail++; $display("FAIL reset_count[%0d]: got %0d required 0", d, cnt[d]); end
    end
    // seed_in of zero selects the default seed; a nonzero seed loads as-is.
    sload[0] = 1'b1;
    sin[0]   = 16'h0000;
    sload[1] = 1'b1;
    sin[1]   = 16'h1234;
    @(negedge clk);
    sload = '0;
    n_tests += 2;
    if (dut0.lfsr_q !== 16'hACE1) begin
      n_fail++;
      $display("FAIL seed_zero: got %04h required ace1", dut0.lfsr_q);
    end
    if (dut1.lfsr_q !== 16'h1234) begin
      n_fail++;
      $display("FAIL seed_load: got %04h required 1234", dut1.lfsr_q);
    end
  endtask

  task automatic test_full16();
    for (int i = 0; i < 16; i++) do_req(0, 1'b0, 0);
    n_tests++;
    if (m_seen[0] != 16'hFFFF || all[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL full16_all: got all_selected %0b required 1", all[0]);
    end
  endtask

  task automatic test_exhaust9();
    int  pulses;
    bit  dropped;
    for (int i = 0; i < 9; i++) do_req(1, 1'b0, 0);
    req[1]  = 1'b1;
    pulses  = 0;
    dropped = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done[1]) pulses++;
      if (all[1] !== 1'b1) dropped = 1'b1;
    end
    req[1] = 1'b0;
    @(negedge clk);
    n_tests += 3;
    if (pulses != 0) begin
      n_fail++;
      $display("FAIL exhausted_done: got %0d pulses required 0", pulses);
    end
    if (dropped) begin
      n_fail++;
      $display("FAIL exhausted_all: got a low cycle required 1 throughout");
    end
    if (cnt[1] !== 5'd9) begin
      n_fail++;
      $display("FAIL exhausted_count: got %0d required 9", cnt[1]);
    end
  endtask

  task automatic test_auto_clear();
    // The fifth request finds the round exhausted and restarts it.
    for (int i = 0; i < 5; i++) do_req(2, 1'b0, 0);
  endtask

  task automatic test_back_to_back_hold();
    pulse_clear(1);
    do_req(1, 1'b0, 20);
    do_req(1, 1'b0, 0);
  endtask

  task automatic test_clear_on_hit();
    pulse_clear(0);
    for (int i = 0; i < 5; i++) do_req(0, 1'b0, 0);
    do_req(0, 1'b1, 0);
    for (int i = 0; i < 16; i++) do_req(0, 1'b0, 0);
  endtask

  task automatic test_async_reset();
    logic [3:0] pick;
    int         p;
    int         pulses;
    pulse_clear(0);
    predict(m_lfsr[0][3:0], m_seen[0], 16, pick, p);
    req[0] = 1'b1;
    repeat (p) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    n_tests += 4;
    if (done[0] !== 1'b0) begin n_fail++; $display("FAIL areset_done: got %0b required 0", done[0]); end
    if (num[0] !== 4'd0)  begin n_fail++; $display("FAIL areset_number: got %0d required 0", num[0]); end
    if (cnt[0] !== 5'd0)  begin n_fail++; $display("FAIL areset_count: got %0d required 0", cnt[0]); end
    if (all[0] !== 1'b0)  begin n_fail++; $display("FAIL areset_all: got %0b required 0", all[0]); end
    @(negedge clk);
    req[0] = 1'b0;
    rst    = 1'b1;
    for (int d = 0; d < 3; d++) begin
      m_seen[d]  = '0;
      m_count[d] = 0;
    end
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done[0]) pulses++;
    end
    n_tests++;
    if (pulses != 0) begin
      n_fail++;
      $display("FAIL areset_pending_done: got %0d pulses required 0", pulses);
    end
  endtask

  initial begin
    test_reset();
    test_full16();
    test_exhaust9();
    test_auto_clear();
    test_back_to_back_hold();
    test_clear_on_hit();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
